// File: rtl/attack_pkg.sv
// Shared types and constants for the attack-phase timing meter and the key-edge decoder.
// Used by attack_meter and attack_key_edge (also reused by the menu).
package attack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } attack_state_e;

  localparam logic [7:0] SPACE_CODE = 8'h29;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  localparam logic [9:0] FRAME_X = 10'd639;
  localparam logic [9:0] FRAME_Y = 10'd479;

  // The last visible pixel of the frame marks one frame step.
  function automatic logic is_frame_tick(input logic [9:0] sx, input logic [9:0] sy);
    return (sx == FRAME_X) && (sy == FRAME_Y);
  endfunction

endpackage

// File: rtl/attack_key_edge.sv
// Space-key decoder: registers the make-code match and emits a one-cycle pulse on its rising edge.
// A held key produces a single pulse; a break-prefixed code reads as released.
module attack_key_edge
  import attack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key,
  output logic        press_pulse
);

  logic press_raw;
  logic press_lvl;

  assign press_raw = (key[7:0] == SPACE_CODE) && (key[15:8] != BREAK_CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_lvl   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_lvl   <= press_raw;
      press_pulse <= press_raw & ~press_lvl;
    end
  end

endmodule

// File: rtl/attack_meter.sv
// Multi-hit attack timing meter: sweeps N_HITS cursors across the target bar and scores each one.
// Optional build macro ATTACK_METER_FLASH_EN makes the scored cursor blink during HOLD.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | phase inactive; waits for phase_en rising edge
// SWEEP | cursor idx moves one STEP per frame; press or far edge scores
// HOLD  | scored cursor stays on screen for HOLD_FRAMES frame ticks
// DONE  | all cursors scored and held; done=1 until phase_en drops
module attack_meter
  import attack_pkg::*;
#(
  parameter int LEFT        = 120,
  parameter int RIGHT       = 520,
  parameter int TOP         = 150,
  parameter int BOTTOM      = 330,
  parameter int BAR_W       = 5,
  parameter int STEP        = 5,
  parameter int N_HITS      = 3,
  parameter int HOLD_FRAMES = 16,
  parameter int DMG_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               phase_en,
  input  logic [15:0]        key,
  output logic               sprite_on,
  output logic               hit_valid,
  output logic [DMG_W-1:0]   hit_damage,
  output logic [1:0]         hit_index,
  output logic [DMG_W+1:0]   total_damage,
  output logic               done
);

  localparam int CENTER = (LEFT + RIGHT) / 2;
  localparam int HOLD_W = ($clog2(HOLD_FRAMES) < 3) ? 3 : $clog2(HOLD_FRAMES);

  localparam logic [10:0] P_LEFT   = 11'(LEFT);
  localparam logic [10:0] P_RIGHT  = 11'(RIGHT);
  localparam logic [10:0] P_CENTER = 11'(CENTER);
  localparam logic [10:0] P_END_R  = 11'(RIGHT - BAR_W);
  localparam logic [10:0] P_STEP   = 11'(STEP);
  localparam logic [10:0] P_BAR_W  = 11'(BAR_W);
  localparam logic [10:0] P_TOP    = 11'(TOP);
  localparam logic [10:0] P_BOTTOM = 11'(BOTTOM);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);

  attack_state_e state, state_nxt;

  logic [9:0]        pos;
  logic [1:0]        idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              phase_q;
  logic              press_pulse;
  logic              frame_tick;

  logic              start;
  logic              score_hit;
  logic              score_miss;
  logic              advance;
  logic              hold_dec;
  logic              hold_done;
  logic              last_cursor;
  logic              at_end;
  logic [10:0]       pos_ext;
  logic [9:0]        pos_moved;
  logic [9:0]        pos_clamp;
  logic [9:0]        pos_reload;
  logic [DMG_W-1:0]  hit_dmg;
  logic              hold_vis;
  logic              cursor_vis;
  logic              sprite_nxt;

  attack_key_edge u_key_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .press_pulse (press_pulse)
  );

  assign frame_tick  = is_frame_tick(x, y);
  assign pos_ext     = {1'b0, pos};
  assign last_cursor = (({1'b0, idx} + 3'd1) == 3'(N_HITS));

  // Even cursors travel right from LEFT, odd cursors travel left from the right end.
  always_comb begin
    if (idx[0] == 1'b0) begin
      at_end    = (pos_ext + P_STEP) > P_END_R;
      pos_moved = 10'(pos_ext + P_STEP);
      pos_clamp = 10'(P_END_R);
    end else begin
      at_end    = pos_ext < (P_LEFT + P_STEP);
      pos_moved = 10'(pos_ext - P_STEP);
      pos_clamp = 10'(P_LEFT);
    end
    pos_reload = idx[0] ? 10'(P_LEFT) : 10'(P_END_R);
  end

  // Distance from the nearer bar edge, so the centre pays the most.
  always_comb begin
    hit_dmg = '0;
    if (score_hit) begin
      if (pos_ext <= P_CENTER) hit_dmg = DMG_W'(pos_ext - P_LEFT);
      else                     hit_dmg = DMG_W'(P_RIGHT - pos_ext);
    end
  end

`ifdef ATTACK_METER_FLASH_EN
  assign hold_vis = ~hold_cnt[2];
`else
  assign hold_vis = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    score_hit  = 1'b0;
    score_miss = 1'b0;
    advance    = 1'b0;
    hold_dec   = 1'b0;
    hold_done  = 1'b0;
    if (!phase_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!phase_q) begin
            start     = 1'b1;
            state_nxt = SWEEP;
          end
        end
        SWEEP: begin
          if (press_pulse) begin
            score_hit = 1'b1;
            state_nxt = HOLD;
          end else if (frame_tick) begin
            if (at_end) begin
              score_miss = 1'b1;
              state_nxt  = HOLD;
            end else begin
              advance = 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == '0) begin
              hold_done = 1'b1;
              state_nxt = last_cursor ? DONE : SWEEP;
            end else begin
              hold_dec = 1'b1;
            end
          end
        end
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cursor_vis = 1'b0;
    unique case (state)
      SWEEP:   cursor_vis = 1'b1;
      HOLD:    cursor_vis = hold_vis;
      default: cursor_vis = 1'b0;
    endcase
    sprite_nxt = phase_en && cursor_vis
              && ({1'b0, x} >= pos_ext) && ({1'b0, x} < (pos_ext + P_BAR_W))
              && ({1'b0, y} >= P_TOP)   && ({1'b0, y} < P_BOTTOM);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      sprite_on    <= 1'b0;
      hit_valid    <= 1'b0;
      hit_damage   <= '0;
      hit_index    <= '0;
      total_damage <= '0;
      pos          <= 10'(P_LEFT);
      idx          <= '0;
      hold_cnt     <= '0;
    end else begin
      phase_q   <= phase_en;
      sprite_on <= sprite_nxt;
      hit_valid <= score_hit | score_miss;

      if (start) begin
        pos          <= 10'(P_LEFT);
        idx          <= '0;
        total_damage <= '0;
      end

      if (score_hit || score_miss) begin
        hit_damage   <= hit_dmg;
        hit_index    <= idx;
        total_damage <= total_damage + (DMG_W + 2)'(hit_dmg);
        hold_cnt     <= HOLD_LOAD;
        if (score_miss) pos <= pos_clamp;
      end else if (advance) begin
        pos <= pos_moved;
      end

      if (hold_dec) hold_cnt <= hold_cnt - 1'b1;

      // The last cursor keeps its index so a 4-hit attack never wraps idx.
      if (hold_done && !last_cursor) begin
        idx <= idx + 2'd1;
        pos <= pos_reload;
      end
    end
  end

endmodule

// File: tb/tb_attack_meter.sv
// Directed bench for attack_meter: a 3-hit and a 1-hit instance share scan/key stimulus.
// Expected hits are queued when a press or miss is provoked and checked when hit_valid fires.
`timescale 1ns/1ps
module tb_attack_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [15:0] key = '0;
  logic        pe3 = 1'b0;
  logic        pe1 = 1'b0;

  logic        s3, hv3, dn3, s1, hv1, dn1;
  logic [9:0]  hd3, hd1;
  logic [1:0]  hi3, hi1;
  logic [11:0] td3, td1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  dmg;
    logic [1:0]  idx;
    logic [11:0] tot;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  attack_meter #(.N_HITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .phase_en(pe3), .key(key),
    .sprite_on(s3), .hit_valid(hv3), .hit_damage(hd3), .hit_index(hi3),
    .total_damage(td3), .done(dn3)
  );

  attack_meter #(.N_HITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .phase_en(pe1), .key(key),
    .sprite_on(s1), .hit_valid(hv1), .hit_damage(hd1), .hit_index(hi1),
    .total_damage(td1), .done(dn1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic expect_hit(input bit d1, input int d, input int i, input int t);
    exp_t e;
    e.dmg = 10'(d);
    e.idx = 2'(i);
    e.tot = 12'(t);
    if (d1) q1.push_back(e);
    else    q3.push_back(e);
  endtask

  always @(negedge clk) begin : mon3
    exp_t e;
    if (hv3 === 1'b1) begin
      check("d3_hit_was_expected", 32'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("d3_hit_damage", hd3, e.dmg);
        check("d3_hit_index", hi3, e.idx);
        check("d3_total_damage", td3, e.tot);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (hv1 === 1'b1) begin
      check("d1_hit_was_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d1_hit_damage", hd1, e.dmg);
        check("d1_hit_index", hi1, e.idx);
        check("d1_total_damage", td1, e.tot);
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic ticks(input int n);
    repeat (n) begin
      x = 10'd639;
      y = 10'd479;
      @(negedge clk);
    end
    x = '0;
    y = '0;
  endtask

  task automatic spr(input string tag, input bit d1, input int xx, input logic expv);
    x = 10'(xx);
    y = 10'd200;
    @(negedge clk);
    check(tag, d1 ? s1 : s3, expv);
    x = '0;
    y = '0;
  endtask

  task automatic press(input bit d1, input int d, input int i, input int t);
    expect_hit(d1, d, i, t);
    key = 16'h0029;
    @(negedge clk);
    @(negedge clk);
    key = 16'hF029;
    @(negedge clk);
    key = 16'h0000;
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sprite", s3, 0);
    check("rst_hit_valid", hv3, 0);
    check("rst_hit_damage", hd3, 0);
    check("rst_hit_index", hi3, 0);
    check("rst_total", td3, 0);
    check("rst_done", dn3, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cursor attack: centre-left press, then hold and done.
    pe1 = 1'b1;
    @(negedge clk);
    ticks(20);
    spr("d1_sweep_at_220", 1, 220, 1);
    spr("d1_right_of_bar", 1, 225, 0);
    press(1, 100, 0, 100);
    ticks(4);
    spr("d1_hold_visible", 1, 220, 1);
    ticks(11);
    check("d1_done_before_expiry", dn1, 0);
    ticks(1);
    check("d1_done_on_expiry", dn1, 1);
    spr("d1_done_hidden", 1, 220, 0);
    check("d1_total_after_done", td1, 100);
    pe1 = 1'b0;
    @(negedge clk);
    check("d1_done_clears", dn1, 0);

    // Three cursors: 50, miss at the left edge, 150.
    pe3 = 1'b1;
    @(negedge clk);
    ticks(10);
    press(0, 50, 0, 50);
    ticks(4);
    spr("d3_hold_c0", 0, 170, 1);
    ticks(12);
    spr("d3_c1_start_515", 0, 515, 1);
    spr("d3_c1_left_of_515", 0, 514, 0);
    ticks(79);
    spr("d3_c1_at_left", 0, 120, 1);
    expect_hit(0, 0, 1, 50);
    ticks(1);
    ticks(4);
    spr("d3_miss_clamped", 0, 120, 1);
    spr("d3_miss_no_overshoot", 0, 115, 0);
    ticks(12);
    ticks(30);
    press(0, 150, 2, 200);
    ticks(15);
    check("d3_done_before_expiry", dn3, 0);
    ticks(1);
    check("d3_done_on_expiry", dn3, 1);
    check("d3_total_200", td3, 200);
    check("d3_last_index", hi3, 2);
    pe3 = 1'b0;
    @(negedge clk);
    check("d3_done_clears", dn3, 0);
    check("d3_total_holds", td3, 200);

    // Right-of-centre press, key held through HOLD, coincident press/tick, far-edge miss.
    pe3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("d3_total_cleared", td3, 0);
    ticks(60);
    expect_hit(0, 100, 0, 100);
    key = 16'h0029;
    @(negedge clk);
    @(negedge clk);
    ticks(16);
    ticks(39);
    key = 16'hF029;
    @(negedge clk);
    key = 16'h0029;
    @(negedge clk);
    expect_hit(0, 200, 1, 300);
    ticks(1);
    ticks(4);
    spr("d3_coincident_premove", 0, 320, 1);
    spr("d3_coincident_not_moved", 0, 315, 0);
    key = 16'h0000;
    ticks(12);
    ticks(79);
    spr("d3_c2_reaches_515", 0, 515, 1);
    expect_hit(0, 0, 2, 300);
    ticks(1);
    ticks(15);
    ticks(1);
    check("d3_done_after_miss", dn3, 1);
    check("d3_total_300", td3, 300);
    pe3 = 1'b0;
    @(negedge clk);

    // phase_en dropped mid-sweep with a press in flight.
    pe3 = 1'b1;
    @(negedge clk);
    ticks(5);
    spr("d3_sweep_145", 0, 145, 1);
    pe3 = 1'b0;
    key = 16'h0029;
    x = 10'd145;
    y = 10'd200;
    @(negedge clk);
    check("d3_drop_sprite_off", s3, 0);
    repeat (3) @(negedge clk);
    check("d3_drop_still_off", s3, 0);
    check("d3_drop_no_done", dn3, 0);
    check("d3_drop_total", td3, 0);
    key = 16'h0000;
    x = '0;
    y = '0;
    @(negedge clk);

    // Asynchronous reset mid-sweep with a press in flight.
    pe3 = 1'b1;
    @(negedge clk);
    ticks(20);
    press(0, 100, 0, 100);
    ticks(16);
    ticks(10);
    spr("d3_c1_at_465", 0, 465, 1);
    key = 16'h0029;
    rst_n = 1'b0;
    #1;
    check("arst_hit_damage", hd3, 0);
    check("arst_total", td3, 0);
    check("arst_hit_valid", hv3, 0);
    check("arst_sprite", s3, 0);
    pe3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key = 16'h0000;
    spr("arst_idle_hidden", 0, 120, 0);
    check("arst_done", dn3, 0);
    check("arst_index", hi3, 0);

    repeat (4) @(negedge clk);
    check("d3_all_hits_seen", q3.size(), 0);
    check("d1_all_hits_seen", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
